// File: rtl/pixel_scan_pkg.sv
// Shared types for the pixel scan generator: FSM states, move directions, scan order.
package pixel_scan_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} scan_state_t;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_NONE  = 2'b11
    } scan_dir_t;

    typedef enum logic {MODE_RASTER = 1'b0, MODE_SERP = 1'b1} scan_mode_t;

endpackage

// File: rtl/pixel_scan_gen_if.sv
// Position stream from the scan generator to window/score logic (valid/ready).
interface pixel_scan_gen_if import pixel_scan_pkg::*; #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          pos_valid;
    logic          pos_ready;
    logic [XW-1:0] curr_x;
    logic [YW-1:0] curr_y;
    scan_dir_t     next_dir;
    logic          last;

    modport master (output pos_valid, curr_x, curr_y, next_dir, last, input pos_ready);
    modport slave  (input pos_valid, curr_x, curr_y, next_dir, last, output pos_ready);
endinterface

// File: rtl/scan_axis_ctr.sv
// One scan axis: coordinate register with load / step by stride, plus flags telling
// whether another stride step would cross the low or high bound.
module scan_axis_ctr #(
    parameter int W  = 10,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [W-1:0]  i_load_val,
    input  logic          i_up,
    input  logic          i_dn,
    input  logic [SW-1:0] i_stride,
    input  logic [W-1:0]  i_lo,
    input  logic [W-1:0]  i_hi,
    output logic [W-1:0]  o_val,
    output logic          o_at_lo,
    output logic          o_at_hi
);
    localparam int CW = W + SW + 1;

    logic [W-1:0]  r_val;
    logic [CW-1:0] w_val_c;
    logic [CW-1:0] w_stp_c;

    // Widened so val+stride and lo+stride can never wrap.
    assign w_val_c = CW'(r_val);
    assign w_stp_c = CW'(i_stride);
    assign o_at_hi = (w_val_c + w_stp_c) > CW'(i_hi);
    assign o_at_lo = w_val_c < (CW'(i_lo) + w_stp_c);
    assign o_val   = r_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_val <= '0;
        else if (i_load) r_val <= i_load_val;
        else if (i_up)   r_val <= r_val + W'(i_stride);
        else if (i_dn)   r_val <= r_val - W'(i_stride);
    end

endmodule

// File: rtl/pixel_scan_gen.sv
// ROI pixel position generator: validates a latched frame config, then walks the
// bordered region in raster or serpentine order over a valid/ready stream.
module pixel_scan_gen import pixel_scan_pkg::*; #(
    parameter  int X_MAX      = 640,
    parameter  int Y_MAX      = 480,
    parameter  int STRIDE_MAX = 8,
    localparam int XW         = $clog2(X_MAX + 1),
    localparam int YW         = $clog2(Y_MAX + 1),
    localparam int SW         = $clog2(STRIDE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XW-1:0]     cfg_max_x,
    input  logic [YW-1:0]     cfg_max_y,
    input  logic [3:0]        cfg_border,
    input  logic [SW-1:0]     cfg_stride,
    input  logic              cfg_mode,
    pixel_scan_gen_if.master  pos,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CXW = XW + SW + 1;
    localparam int CYW = YW + SW + 1;
    localparam logic [SW-1:0] SMAX = SW'(STRIDE_MAX);

    scan_state_t   r_state;
    scan_mode_t    r_mode;
    logic [XW-1:0] r_max_x, r_x_hi, r_x_end;
    logic [YW-1:0] r_max_y, r_y_hi;
    logic [3:0]    r_border;
    logic [SW-1:0] r_stride;
    logic          r_row_odd, r_pos_valid, r_busy, r_done, r_err;

    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic          w_x_at_lo, w_x_at_hi, w_y_at_lo, w_y_at_hi;
    logic          w_serp, w_left_row, w_row_end, w_last, w_acc, w_bad;
    scan_dir_t     w_dir;

    // Checked on the incoming config so err can be raised during the CHECK cycle.
    assign w_bad = (cfg_max_x == '0) || (cfg_max_y == '0) || (cfg_stride == '0) ||
                   (cfg_stride > SMAX) ||
                   ((CXW'(cfg_border) << 1) >= CXW'(cfg_max_x)) ||
                   ((CYW'(cfg_border) << 1) >= CYW'(cfg_max_y));

    assign w_serp     = (r_mode == MODE_SERP);
    assign w_left_row = w_serp && r_row_odd;
    assign w_acc      = r_pos_valid && pos.pos_ready;

    // Serpentine rows after row 0 end where row 0 ended (the recorded x_end).
    always_comb begin
        w_row_end = w_x_at_hi;
        if (w_left_row)                  w_row_end = w_x_at_lo;
        else if (w_serp && !w_y_at_lo)   w_row_end = (w_x == r_x_end);
    end

    assign w_last = (r_state == SCAN) && w_row_end && w_y_at_hi;

    always_comb begin
        w_dir = DIR_RIGHT;
        if (r_state == SCAN) begin
            if (w_last)          w_dir = DIR_NONE;
            else if (w_row_end)  w_dir = DIR_DOWN;
            else if (w_left_row) w_dir = DIR_LEFT;
        end
    end

    scan_axis_ctr #(.W(XW), .SW(SW)) u_x_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     ((r_state == CHECK) || (w_acc && w_dir == DIR_DOWN && !w_serp)),
        .i_load_val (XW'(r_border)),
        .i_up       (w_acc && w_dir == DIR_RIGHT),
        .i_dn       (w_acc && w_dir == DIR_LEFT),
        .i_stride   (r_stride),
        .i_lo       (XW'(r_border)),
        .i_hi       (r_x_hi),
        .o_val      (w_x),
        .o_at_lo    (w_x_at_lo),
        .o_at_hi    (w_x_at_hi)
    );

    scan_axis_ctr #(.W(YW), .SW(SW)) u_y_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == CHECK),
        .i_load_val (YW'(r_border)),
        .i_up       (w_acc && w_dir == DIR_DOWN),
        .i_dn       (1'b0),
        .i_stride   (r_stride),
        .i_lo       (YW'(r_border)),
        .i_hi       (r_y_hi),
        .o_val      (w_y),
        .o_at_lo    (w_y_at_lo),
        .o_at_hi    (w_y_at_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= MODE_RASTER;
            r_max_x     <= '0;
            r_max_y     <= '0;
            r_border    <= '0;
            r_stride    <= '0;
            r_x_hi      <= '0;
            r_y_hi      <= '0;
            r_x_end     <= '0;
            r_row_odd   <= 1'b0;
            r_pos_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            // start wins in every state: it aborts any scan without a done pulse.
            if (start) begin
                r_max_x     <= cfg_max_x;
                r_max_y     <= cfg_max_y;
                r_border    <= cfg_border;
                r_stride    <= cfg_stride;
                r_mode      <= scan_mode_t'(cfg_mode);
                r_err       <= w_bad;
                r_busy      <= !w_bad;
                r_pos_valid <= 1'b0;
                r_state     <= CHECK;
            end else begin
                case (r_state)
                    IDLE: ;
                    CHECK: begin
                        if (r_err) begin
                            r_state <= IDLE;
                        end else begin
                            r_x_hi      <= r_max_x - XW'(1) - XW'(r_border);
                            r_y_hi      <= r_max_y - YW'(1) - YW'(r_border);
                            r_row_odd   <= 1'b0;
                            r_pos_valid <= 1'b1;
                            r_state     <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (w_acc) begin
                            if (w_last) begin
                                r_pos_valid <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= DONE;
                            end else if (w_dir == DIR_DOWN) begin
                                r_row_odd <= !r_row_odd;
                                if (w_y_at_lo) r_x_end <= w_x;
                            end
                        end
                    end
                    DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign pos.pos_valid = r_pos_valid;
    assign pos.curr_x    = w_x;
    assign pos.curr_y    = w_y;
    assign pos.next_dir  = w_dir;
    assign pos.last      = w_last;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Directed bench for pixel_scan_gen: raster, serpentine, border/stride, stall,
// config rejection, abort and reset cases with hand-derived positions.
module tb_pixel_scan_gen;
    import pixel_scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [9:0] cfg_max_x = '0;
    logic [8:0] cfg_max_y = '0;
    logic [3:0] cfg_border = '0;
    logic [3:0] cfg_stride = '0;
    logic       cfg_mode = 1'b0;
    logic       busy, done, err;
    int         checks = 0;
    int         failures = 0;

    pixel_scan_gen_if #(.XW(10), .YW(9)) pif ();

    pixel_scan_gen dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_max_x  (cfg_max_x),
        .cfg_max_y  (cfg_max_y),
        .cfg_border (cfg_border),
        .cfg_stride (cfg_stride),
        .cfg_mode   (cfg_mode),
        .pos        (pif),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, err, pos_valid, last, next_dir, curr_y, curr_x}
    function automatic logic [31:0] stat();
        return {6'd0, busy, done, err, pif.pos_valid, pif.last, pif.next_dir, pif.curr_y, pif.curr_x};
    endfunction

    task automatic cfg_start(input int mx, input int my, input int b, input int s, input int m);
        cfg_max_x  = 10'(mx);
        cfg_max_y  = 9'(my);
        cfg_border = 4'(b);
        cfg_stride = 4'(s);
        cfg_mode   = 1'(m);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Check the presented position, then let one clock edge go by.
    task automatic exp_pos(input string tag, input int x, input int y, input int d, input int l);
        chk(tag, {9'd0, pif.pos_valid, pif.last, pif.next_dir, pif.curr_y, pif.curr_x},
                 {9'd0, 1'b1, 1'(l), 2'(d), 9'(y), 10'(x)});
        tick();
    endtask

    initial begin
        pif.pos_ready = 1'b1;
        repeat (2) tick();
        chk("reset_outputs", stat(), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", stat(), 32'd0);

        // 5x5 raster, stride 1
        cfg_start(5, 5, 0, 1, 0);
        chk("t1_check_no_valid", 32'(pif.pos_valid), 32'd0);
        tick();
        for (int k = 0; k < 25; k++)
            exp_pos("t1_raster", k % 5, k / 5, (k == 24) ? 3 : ((k % 5 == 4) ? 2 : 0), (k == 24) ? 1 : 0);
        chk("t1_done", {29'd0, done, busy, pif.pos_valid}, 32'b110);
        tick();
        chk("t1_idle", {30'd0, done, busy}, 32'd0);

        // 4x3 serpentine
        cfg_start(4, 3, 0, 1, 1);
        tick();
        exp_pos("t2_serp", 0, 0, 0, 0);
        exp_pos("t2_serp", 1, 0, 0, 0);
        exp_pos("t2_serp", 2, 0, 0, 0);
        exp_pos("t2_serp", 3, 0, 2, 0);
        exp_pos("t2_serp", 3, 1, 1, 0);
        exp_pos("t2_serp", 2, 1, 1, 0);
        exp_pos("t2_serp", 1, 1, 1, 0);
        exp_pos("t2_serp", 0, 1, 2, 0);
        exp_pos("t2_serp", 0, 2, 0, 0);
        exp_pos("t2_serp", 1, 2, 0, 0);
        exp_pos("t2_serp", 2, 2, 0, 0);
        exp_pos("t2_serp", 3, 2, 3, 1);
        chk("t2_done", 32'(done), 32'd1);
        tick();

        // 10x10, border 3, stride 2: bounds 3..6
        cfg_start(10, 10, 3, 2, 0);
        tick();
        exp_pos("t3_border", 3, 3, 0, 0);
        exp_pos("t3_border", 5, 3, 2, 0);
        exp_pos("t3_border", 3, 5, 0, 0);
        exp_pos("t3_border", 5, 5, 3, 1);
        chk("t3_done", {30'd0, done, pif.pos_valid}, 32'b10);
        tick();

        // 5x5 raster with a 3-cycle stall at (2,0)
        cfg_start(5, 5, 0, 1, 0);
        tick();
        exp_pos("t4_pre", 0, 0, 0, 0);
        exp_pos("t4_pre", 1, 0, 0, 0);
        pif.pos_ready = 1'b0;
        repeat (3) exp_pos("t4_stall", 2, 0, 0, 0);
        pif.pos_ready = 1'b1;
        for (int k = 2; k < 25; k++)
            exp_pos("t4_post", k % 5, k / 5, (k == 24) ? 3 : ((k % 5 == 4) ? 2 : 0), (k == 24) ? 1 : 0);
        chk("t4_done", 32'(done), 32'd1);
        tick();

        // rejected configurations
        cfg_start(6, 10, 3, 1, 0);
        chk("t5_border_err", {29'd0, err, busy, pif.pos_valid}, 32'b100);
        tick();
        chk("t5_border_after", {29'd0, err, busy, pif.pos_valid}, 32'd0);
        tick();
        chk("t5_border_idle", {29'd0, err, busy, pif.pos_valid}, 32'd0);
        cfg_start(5, 5, 0, 0, 0);
        chk("t5_stride0_err", {29'd0, err, busy, pif.pos_valid}, 32'b100);
        tick();
        chk("t5_stride0_after", {29'd0, err, busy, pif.pos_valid}, 32'd0);
        cfg_start(20, 20, 0, 9, 0);
        chk("t5_stride9_err", 32'(err), 32'd1);
        tick();
        chk("t5_stride9_after", {30'd0, err, pif.pos_valid}, 32'd0);

        // 7x7 border 3 is the tightest legal border: a single position
        cfg_start(7, 7, 3, 1, 1);
        chk("t5_tight_no_err", 32'(err), 32'd0);
        tick();
        exp_pos("t5_single", 3, 3, 3, 1);
        chk("t5_single_done", 32'(done), 32'd1);
        tick();

        // abort mid-scan with a 3x3 config
        cfg_start(5, 5, 0, 1, 0);
        tick();
        exp_pos("t6_old", 0, 0, 0, 0);
        exp_pos("t6_old", 1, 0, 0, 0);
        exp_pos("t6_old", 2, 0, 0, 0);
        cfg_start(3, 3, 0, 1, 0);
        chk("t6_abort", {30'd0, done, pif.pos_valid}, 32'd0);
        tick();
        for (int k = 0; k < 9; k++)
            exp_pos("t6_new", k % 3, k / 3, (k == 8) ? 3 : ((k % 3 == 2) ? 2 : 0), (k == 8) ? 1 : 0);
        chk("t6_done", 32'(done), 32'd1);
        tick();

        // reset mid-scan
        cfg_start(5, 5, 0, 1, 0);
        tick();
        exp_pos("t7_pre", 0, 0, 0, 0);
        exp_pos("t7_pre", 1, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("t7_rst_async", stat(), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t7_rst_after", stat(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
